fn_equiv_sweeper: RTL
=====================

Name: fn_equiv_sweeper

Overview:
- Sequencer that drives an exhaustive input sweep through two external combinational function units: the SOP unit (f) and the POS unit (g).
- Compares f_in against g_in for every N-bit input vector.
- Reports the mismatch count, the first mismatching vector and start/busy/done status.
- Sits between a test/config master and the paired function units, which read the vec bus.

Parameters:
- N, 5, input vector width; sweep covers 0 .. 2^N-1.
- SETTLE, 0, extra hold cycles per vector before compare (covers registered or slow units).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  launch sweep; accepted only in IDLE
- abort  in  1  cancel sweep in progress
- stop_on_err  in  1  sampled with start; 1 = finish at first mismatch
- f_in  in  1  SOP unit output for current vec
- g_in  in  1  POS unit output for current vec
- vec  out  N  registered vector driven to both units; bit N-1 = x1, bit 0 = xN
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on completion
- err_seen  out  1  at least one mismatch in last/current sweep
- err_cnt  out  N+1  mismatch count, range 0..2^N
- first_err_vec  out  N  vec of first mismatch; 0 if none

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - vec, busy, done, err_seen, err_cnt, first_err_vec, settle counter and stop flag all = 0.
  - Reset overrides everything, including mid-sweep.
- States:
  - IDLE: busy=0; results hold the last sweep's values.
  - start=1 & abort=0 -> RUN.
  - At that edge: vec<=0, err_cnt<=0, err_seen<=0, first_err_vec<=0, settle_cnt<=0, stop flag<=stop_on_err.
  - RUN: busy=1. Each vec is held SETTLE+1 cycles; settle_cnt counts 0..SETTLE.
  - Compare cycle is settle_cnt==SETTLE. There, mismatch = f_in ^ g_in, sampled combinationally on that cycle.
  - On mismatch: err_cnt++. If err_seen==0, first_err_vec<=vec. Then err_seen<=1.
  - Advance: after the compare cycle, settle_cnt<=0 and vec<=vec+1.
  - Exit to DONE if vec==2^N-1, or if (mismatch & stop flag). vec then holds its last value, with no wrap.
  - DONE: exactly one cycle; done=1, busy=0; then -> IDLE.
- Latency:
  - Start sampled at edge T: RUN occupies cycles T+1 .. T+2^N*(SETTLE+1).
  - done is high in cycle T+2^N*(SETTLE+1)+1.
- Boundary and priority rules:
  - abort in RUN: -> IDLE next edge. No done pulse; partial results retained; vec unchanged.
  - abort outranks a final compare in the same cycle.
  - start during RUN or DONE: ignored.
  - start & abort together in IDLE: stays IDLE.
  - stop_on_err changes during RUN: ignored.
  - err_cnt is N+1 bits wide, so the all-mismatch case (2^N) does not overflow.
  - f_in/g_in are ignored outside compare cycles; X on them is harmless then.

Test Plan:
- Bench units use vec={x1..x5}:
  - f = x2~x3~x4 + ~x2x3 + ~x2x4 + x1x2~x4 + x1x2~x3~x5
  - g = (x2+x3+x4)(~x2+~x4+x5)(x1+~x2+~x3)(~x2+x3+~x4+~x5)
- Full sweep: N=5, SETTLE=0, start at T, stop_on_err=0 -> busy T+1..T+32, done pulse at T+33, err_cnt=2, err_seen=1, first_err_vec=5'b11010 (26). Mismatching vectors are 26 and 31.
- Stop on error: as above with stop_on_err=1 -> done at T+28, err_cnt=1, first_err_vec=26, vec=26.
- Settle: SETTLE=2, full sweep -> each vec held 3 cycles, done at T+97, err_cnt=2.
- Equivalent units: g_in tied to f_in -> done at T+33, err_cnt=0, err_seen=0, first_err_vec=0.
- Abort and reset:
  - abort at T+10 -> IDLE at T+11, no done, busy=0.
  - New start at T+12 re-clears results; the sweep completes normally.
  - rst_n=0 at T+5 mid-run -> all outputs 0 next cycle.
- Ignored start: pulse start at T+3 during a sweep -> no effect; done still at T+33.

Source files
------------

// File: rtl/fn_equiv_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : fn_equiv_sweeper
//  Description : Exhaustive equivalence sweeper for two combinational function
//                units. It drives every N-bit vector on vec, waits SETTLE
//                extra cycles, compares f_in against g_in, and reports the
//                mismatch count, the first mismatching vector and status.
//  Revision    : 1.0 - initial release
// ============================================================================
module fn_equiv_sweeper #(
    parameter int N      = 5,
    parameter int SETTLE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         stop_on_err,
    input  logic         f_in,
    input  logic         g_in,
    output logic [N-1:0] vec,
    output logic         busy,
    output logic         done,
    output logic         err_seen,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err_vec
);

    // A zero SETTLE still needs a one-bit counter so the compare test stays uniform.
    localparam int              SW            = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0]   C_SETTLE_LAST = SW'(SETTLE);
    localparam logic [N-1:0]    C_VEC_LAST    = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   vec_q, vec_d;
    logic [N:0]     err_cnt_q, err_cnt_d;
    logic           err_seen_q, err_seen_d;
    logic [N-1:0]   first_q, first_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic           stop_q, stop_d;
    logic           w_cmp;
    logic           w_mis;

    // Mismatch is only meaningful on the last hold cycle of a vector in RUN;
    // gating here keeps X on the unit outputs from leaking in at other times.
    assign w_cmp = (state_q == S_RUN) && (settle_q == C_SETTLE_LAST);
    assign w_mis = w_cmp && (f_in ^ g_in);

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        err_cnt_d  = err_cnt_q;
        err_seen_d = err_seen_q;
        first_d    = first_q;
        settle_d   = settle_q;
        stop_d     = stop_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d    = S_RUN;
                    vec_d      = '0;
                    err_cnt_d  = '0;
                    err_seen_d = 1'b0;
                    first_d    = '0;
                    settle_d   = '0;
                    stop_d     = stop_on_err;
                end
            end

            S_RUN: begin
                if (abort) begin
                    // Abort wins over any compare this cycle; results freeze as-is.
                    state_d = S_IDLE;
                end else if (settle_q != C_SETTLE_LAST) begin
                    settle_d = settle_q + SW'(1);
                end else begin
                    if (w_mis) begin
                        err_cnt_d  = err_cnt_q + (N+1)'(1);
                        err_seen_d = 1'b1;
                        if (!err_seen_q) begin
                            first_d = vec_q;
                        end
                    end
                    settle_d = '0;
                    // vec stays on the final vector at exit rather than wrapping.
                    if ((vec_q == C_VEC_LAST) || (w_mis && stop_q)) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d = vec_q + N'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            err_cnt_q  <= '0;
            err_seen_q <= 1'b0;
            first_q    <= '0;
            settle_q   <= '0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            err_cnt_q  <= err_cnt_d;
            err_seen_q <= err_seen_d;
            first_q    <= first_d;
            settle_q   <= settle_d;
            stop_q     <= stop_d;
        end
    end

    assign vec           = vec_q;
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign err_seen      = err_seen_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_vec = first_q;

endmodule
`default_nettype wire
